pwm_fade_sequencer: RTL
=======================

PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the duty, max_value, target and step width.
REQ-002 SHALL have parameter IVL_W, default 8, meaning the width of the step-interval register.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-006 SHALL have port cfg_addr, input, 2 bits: register select (0 target, 1 step, 2 interval, 3 max_value).
REQ-007 SHALL have port cfg_data, input, WIDTH bits: write data (low IVL_W bits for interval).
REQ-008 SHALL have port start, input, 1 bit: begin a fade; level-sampled.
REQ-009 SHALL have port abort, input, 1 bit: stop the fade at the current duty.
REQ-010 SHALL have port duty, output, WIDTH bits: registered duty for the PWM datapath.
REQ-011 SHALL have port max_value, output, WIDTH bits: registered period top for the PWM datapath.
REQ-012 SHALL have port busy, output, 1 bit: high while in RAMP.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL land each cfg_we write into shadow registers only; shadows take effect only when start is accepted.
REQ-015 SHALL accept start only in IDLE; at acceptance, latch the pre-edge shadow values into active registers (a same-cycle write affects the next start only).
REQ-016 SHALL drive max_value from the active max_value register, updated on the cycle after acceptance.
REQ-017 SHALL set eff_target = min(target, max_value), using active values.
REQ-018 SHALL have FSM states IDLE, RAMP and DONE.
- IDLE->RAMP on accepted start.
- RAMP->DONE when duty == eff_target.
- RAMP->IDLE on abort.
- DONE->IDLE unconditionally.
REQ-019 SHALL step duty every (interval+1) clk cycles in RAMP; the first step occurs interval+1 cycles after entry.
REQ-020 SHALL, when stepping upward, compute duty = min(duty+step, eff_target) in WIDTH+1 bits, with no wrap.
REQ-021 SHALL, when stepping downward, compute duty = max(duty-step, eff_target) in WIDTH+1 bits with borrow check, with no wrap.
REQ-022 SHALL treat step == 0 as a jump: duty = eff_target on the first step.
REQ-023 SHALL, if duty == eff_target at entry to RAMP, go to DONE on the next cycle with duty unchanged.
REQ-024 SHALL assert done exactly one cycle in DONE, with busy low in that cycle.
REQ-025 SHALL, on abort in RAMP, return to IDLE next cycle with duty held and no done pulse; abort outside RAMP has no effect.
REQ-026 SHALL give abort priority over start when both are high in the same cycle.
REQ-027 SHALL ignore start while busy or in DONE.
REQ-028 SHALL hold duty constant in IDLE and DONE.

Reset
REQ-029 SHALL, on rst high, immediately force: state IDLE, duty 0, max_value all-ones, busy 0, done 0, interval counter 0.
REQ-030 SHALL reset shadows and active registers to target 0, step 1, interval 0, max_value all-ones.
REQ-031 SHALL abandon a fade in progress when rst asserts mid-ramp, with no done pulse after release.

Structure
REQ-032 SHALL place the FSM state encoding, cfg address constants and register reset values in shared package pwm_seq_pkg.
REQ-033 SHALL implement the interval counter as sub-module step_timer (load, enable, interval input, tick output).
REQ-034 SHALL keep all outputs registered, with no combinational path from inputs to outputs.

Verification
REQ-035 SHALL cover an up-fade: max 255, target 100, step 30, interval 3, start -> duty 30/60/90/100 at 4-cycle spacing, then done one cycle after 100 is reached.
REQ-036 SHALL cover a down-fade with clamp: duty 100, target 0, step 40, interval 0 -> duty 60, 20, 0 on consecutive cycles; done once; no underflow.
REQ-037 SHALL cover target clamping: max 50, target 200, step 0 -> max_value 50, duty 50, done; duty never exceeds 50.
REQ-038 SHALL cover abort: abort mid-ramp at duty 60 -> duty stays 60, busy drops next cycle, no done; a later start resumes from 60.
REQ-039 SHALL cover simultaneous events: start+abort in IDLE -> no fade; cfg_we target 10 together with start -> old target used; start while busy -> ignored.
REQ-040 SHALL cover reset mid-ramp: rst asserted with no clock edge -> duty 0, max_value 255, busy 0 immediately; no done after release.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// Shared state encoding, configuration addresses and reset values for the PWM fade sequencer.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_TARGET = 2'd0;
  localparam logic [1:0] ADDR_STEP   = 2'd1;
  localparam logic [1:0] ADDR_IVL    = 2'd2;
  localparam logic [1:0] ADDR_MAX    = 2'd3;

  // max_value resets to all-ones, expressed as '1 at the point of use
  localparam int RST_TARGET = 0;
  localparam int RST_STEP   = 1;
  localparam int RST_IVL    = 0;

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// Interval counter: tick fires on every (interval+1)-th enabled cycle after a load.
module step_timer #(
  parameter int IVL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [IVL_W-1:0] interval,
  output logic             tick
);

  logic [IVL_W-1:0] count;

  assign tick = enable && (count == interval);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      if (count == interval) count <= '0;
      else                   count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// Fades a registered PWM duty toward a target in fixed steps at a programmable interval.
// Configuration lands in shadow registers and is committed only when a fade starts.
module pwm_fade_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IVL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] max_value,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh_target, sh_step, sh_max;
  logic [IVL_W-1:0] sh_ivl;
  logic [WIDTH-1:0] act_target, act_step;
  logic [IVL_W-1:0] act_ivl;
  logic [WIDTH-1:0] eff_target, duty_nx;
  logic [WIDTH:0]   sum, diff;
  logic             accept, tick;

  assign accept     = (state == ST_IDLE) && start && !abort;
  assign eff_target = (act_target < max_value) ? act_target : max_value;
  assign sum        = {1'b0, duty} + {1'b0, act_step};
  assign diff       = {1'b0, duty} - {1'b0, act_step};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_target <= WIDTH'(RST_TARGET);
      sh_step   <= WIDTH'(RST_STEP);
      sh_ivl    <= IVL_W'(RST_IVL);
      sh_max    <= '1;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_TARGET: sh_target <= cfg_data;
        ADDR_STEP:   sh_step   <= cfg_data;
        ADDR_IVL:    sh_ivl    <= cfg_data[IVL_W-1:0];
        default:     sh_max    <= cfg_data;
      endcase
    end
  end

  // Non-blocking capture means a write in the accept cycle only reaches the next fade
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_target <= WIDTH'(RST_TARGET);
      act_step   <= WIDTH'(RST_STEP);
      act_ivl    <= IVL_W'(RST_IVL);
      max_value  <= '1;
    end else if (accept) begin
      act_target <= sh_target;
      act_step   <= sh_step;
      act_ivl    <= sh_ivl;
      max_value  <= sh_max;
    end
  end

  step_timer #(.IVL_W(IVL_W)) u_step_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .enable   (state == ST_RAMP),
    .interval (act_ivl),
    .tick     (tick)
  );

  always_comb begin
    state_nx = state;
    duty_nx  = duty;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_RAMP;
      end
      ST_RAMP: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (duty == eff_target) begin
          state_nx = ST_DONE;
        end else if (tick) begin
          if (act_step == '0) begin
            duty_nx = eff_target;
          end else if (duty < eff_target) begin
            duty_nx = (sum > {1'b0, eff_target}) ? eff_target : sum[WIDTH-1:0];
          end else begin
            // diff[WIDTH] is the borrow of an underflowing subtraction
            duty_nx = (diff[WIDTH] || (diff < {1'b0, eff_target})) ? eff_target : diff[WIDTH-1:0];
          end
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      duty  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      duty  <= duty_nx;
      busy  <= (state_nx == ST_RAMP);
      done  <= (state_nx == ST_DONE);
    end
  end

endmodule
`default_nettype wire
